// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencer.
//
// Owns the fetch PC and drives a single-outstanding req/gnt/rvalid
// instruction-memory port. One instruction at a time is presented to decode
// on a valid/ready interface. A redirect (trap wins over branch) retargets the
// PC and kills whatever fetch is already committed to the old address.
//
// Parameters
//   width_p     address / instruction width
//   reset_pc_p  first fetch address after reset
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   branch_valid_i, branch_target_i     branch/JAL redirect
//   trap_valid_i, trap_target_i         trap redirect (higher priority)
//   imem_req_o, imem_addr_o             fetch request and address
//   imem_gnt_i                          request accepted
//   imem_rvalid_i, imem_rdata_i         read response
//   instr_valid_o, instr_o, instr_pc_o  instruction to decode
//   instr_ready_i                       decode accepts instruction
module fetch_ctrl #(
  parameter int unsigned         width_p    = 32,
  parameter logic [width_p-1:0]  reset_pc_p = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               branch_valid_i,
  input  logic [width_p-1:0] branch_target_i,
  input  logic               trap_valid_i,
  input  logic [width_p-1:0] trap_target_i,
  output logic               imem_req_o,
  output logic [width_p-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [width_p-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [width_p-1:0] instr_o,
  output logic [width_p-1:0] instr_pc_o,
  input  logic               instr_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] pc_q, pc_d;
  logic [width_p-1:0] pc_next_q, pc_next_d;
  logic               kill_q, kill_d;
  logic [width_p-1:0] instr_q, instr_d;
  logic [width_p-1:0] instr_pc_q, instr_pc_d;

  logic               redirect;
  logic [width_p-1:0] target;

  assign redirect = trap_valid_i | branch_valid_i;
  assign target   = trap_valid_i ? trap_target_i : branch_target_i;

  // The address always reflects pc_q; a redirect while a request is pending
  // only updates pc_next_q, so the address stays stable until the grant.
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign instr_pc_o  = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_next_d     = pc_next_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = target;
      end

      REQ: begin
        imem_req_o = 1'b1;
        // A redirect cannot retract the request already on the bus: the
        // fetch at the old address completes and its response is dropped.
        if (redirect) begin
          pc_next_d = target;
          kill_d    = 1'b1;
        end
        if (imem_gnt_i) state_d = WAIT;
      end

      WAIT: begin
        if (redirect) begin
          pc_next_d = target;
          kill_d    = 1'b1;
        end
        if (imem_rvalid_i) begin
          if (kill_q || redirect) begin
            // A redirect arriving with the response is the latest one.
            pc_d    = redirect ? target : pc_next_q;
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_q;
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        instr_valid_o = ~redirect;
        if (redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + width_p'(4);
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= reset_pc_p;
      pc_next_q  <= reset_pc_p;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_next_q  <= pc_next_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed self-checking bench for fetch_ctrl.
// Memory model: grants whenever gnt_en is set, returns addr ^ 0xDEAD_0000
// exactly one cycle after the grant.
module tb_fetch_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        branch_valid_i;
  logic [31:0] branch_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int unsigned n_checks;
  int unsigned n_fails;

  logic        gnt_en;
  logic        stray_rv;
  logic        fired;
  logic [31:0] addr_f;

  fetch_ctrl #(
    .width_p   (32),
    .reset_pc_p(32'h0000_0000)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .branch_valid_i (branch_valid_i),
    .branch_target_i(branch_target_i),
    .trap_valid_i   (trap_valid_i),
    .trap_target_i  (trap_target_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Memory responder: acts at posedge+1.
  initial begin
    fired         = 1'b0;
    addr_f        = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      imem_rvalid_i = fired | stray_rv;
      imem_rdata_i  = fired ? (addr_f ^ 32'hDEAD_0000) : 32'hBAD0_BAD0;
      fired         = imem_req_o & gnt_en;
      addr_f        = imem_addr_o;
      imem_gnt_i    = fired;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Main thread acts at posedge+2, after the responder.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid_o) break;
    end
    check_eq({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
  endtask

  initial begin
    n_checks        = 0;
    n_fails         = 0;
    rst_ni          = 1'b0;
    branch_valid_i  = 1'b0;
    branch_target_i = '0;
    trap_valid_i    = 1'b0;
    trap_target_i   = '0;
    instr_ready_i   = 1'b1;
    gnt_en          = 1'b1;
    stray_rv        = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_req",    {31'd0, imem_req_o},    32'd0);
    check_eq("rst_addr",   imem_addr_o,            32'h0);
    check_eq("rst_valid",  {31'd0, instr_valid_o}, 32'd0);
    check_eq("rst_instr",  instr_o,                32'h0);
    check_eq("rst_ipc",    instr_pc_o,             32'h0);
    rst_ni = 1'b1;

    // 1: straight-line fetch 0x0, 0x4
    wait_valid("i0");
    check_eq("i0_instr", instr_o,    32'hDEAD_0000);
    check_eq("i0_pc",    instr_pc_o, 32'h0000_0000);
    wait_valid("i1");
    check_eq("i1_instr", instr_o,    32'hDEAD_0004);
    check_eq("i1_pc",    instr_pc_o, 32'h0000_0004);
    gnt_en = 1'b0;

    // 2: gnt low 3 cycles at 0x8, branch to 0x100 in the second
    tick();
    check_eq("t2_req_c1",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t2_addr_c1", imem_addr_o, 32'h8);
    tick();
    branch_valid_i  = 1'b1;
    branch_target_i = 32'h100;
    check_eq("t2_addr_c2", imem_addr_o, 32'h8);
    tick();
    branch_valid_i = 1'b0;
    check_eq("t2_addr_c3", imem_addr_o, 32'h8);
    gnt_en = 1'b1;
    tick();
    check_eq("t2_addr_gnt", imem_addr_o, 32'h8);
    check_eq("t2_gnt",      {31'd0, imem_gnt_i}, 32'd1);
    tick();
    check_eq("t2_wait_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("t2_drop",     {31'd0, instr_valid_o}, 32'd0);
    tick();
    check_eq("t2_req_new",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t2_addr_new", imem_addr_o, 32'h100);
    wait_valid("t2");
    check_eq("t2_instr", instr_o,    32'hDEAD_0100);
    check_eq("t2_pc",    instr_pc_o, 32'h0000_0100);

    // 3: trap + branch together in WAIT, coinciding with rvalid
    tick();
    check_eq("t3_addr", imem_addr_o, 32'h104);
    tick();
    trap_valid_i    = 1'b1;
    trap_target_i   = 32'h200;
    branch_valid_i  = 1'b1;
    branch_target_i = 32'h100;
    tick();
    trap_valid_i   = 1'b0;
    branch_valid_i = 1'b0;
    check_eq("t3_req_new",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t3_addr_new", imem_addr_o, 32'h200);
    instr_ready_i = 1'b0;
    wait_valid("t3");
    check_eq("t3_instr", instr_o,    32'hDEAD_0200);
    check_eq("t3_pc",    instr_pc_o, 32'h0000_0200);

    // 4: stall in HOLD, then branch suppresses valid combinationally
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_valid", {31'd0, instr_valid_o}, 32'd1);
      check_eq("t4_noreq", {31'd0, imem_req_o},    32'd0);
      check_eq("t4_pc",    instr_pc_o,             32'h200);
      tick();
    end
    branch_valid_i  = 1'b1;
    branch_target_i = 32'h40;
    #1;
    check_eq("t4_supp", {31'd0, instr_valid_o}, 32'd0);
    tick();
    branch_valid_i = 1'b0;
    check_eq("t4_addr_new", imem_addr_o, 32'h40);
    wait_valid("t4");
    check_eq("t4_instr", instr_o,    32'hDEAD_0040);
    check_eq("t4_ipc",   instr_pc_o, 32'h0000_0040);

    // 5: PC wrap from 0xFFFF_FFFC
    branch_valid_i  = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_valid_i = 1'b0;
    check_eq("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    instr_ready_i = 1'b1;
    wait_valid("t5");
    check_eq("t5_instr", instr_o,    32'h2152_FFFC);
    check_eq("t5_pc",    instr_pc_o, 32'hFFFF_FFFC);
    tick();
    check_eq("t5_wrap_req",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t5_wrap_addr", imem_addr_o, 32'h0);

    // 6: reset while in WAIT with stray rvalid during and after reset
    tick();
    stray_rv = 1'b1;
    rst_ni   = 1'b0;
    #1;
    check_eq("t6_req",   {31'd0, imem_req_o},    32'd0);
    check_eq("t6_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("t6_instr", instr_o,                32'h0);
    check_eq("t6_ipc",   instr_pc_o,             32'h0);
    check_eq("t6_addr",  imem_addr_o,            32'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    stray_rv = 1'b0;
    check_eq("t6_post_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("t6_post_req",   {31'd0, imem_req_o},    32'd1);
    check_eq("t6_post_addr",  imem_addr_o,            32'h0);
    wait_valid("t6");
    check_eq("t6_first_instr", instr_o,    32'hDEAD_0000);
    check_eq("t6_first_pc",    instr_pc_o, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
